// File: rtl/l15_anycore_req_arbiter.sv
// Arbitrates anycore icache/dcache requests onto the single L1.5 request port.
// Define ANYCORE_REQ_ARB_RR_EN for round-robin; otherwise fixed st > ld > ic.
module l15_anycore_req_arbiter #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_val,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_rdy,
    input  logic              ld_req_val,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [2:0]        ld_req_size,
    output logic              ld_req_rdy,
    input  logic              st_req_val,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [2:0]        st_req_size,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              st_req_rdy,
    output logic              l15_val,
    output logic [4:0]        l15_rqtype,
    output logic [ADDR_W-1:0] l15_address,
    output logic [2:0]        l15_size,
    output logic [DATA_W-1:0] l15_data,
    input  logic              l15_header_ack,
    input  logic              ic_done,
    input  logic              ld_done,
    input  logic              st_done,
    output logic [2:0]        outstanding
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    localparam logic [4:0] IMISS_RQ = 5'b10000;
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    logic [0:0] state;
    logic [2:0] win;
    logic [2:0] elig;
    logic [2:0] grant;
    logic [2:0] rdy;
    logic [2:0] out_nxt;
    logic       accept;

    assign elig = {st_req_val, ld_req_val, ic_req_val} & ~outstanding;

`ifdef ANYCORE_REQ_ARB_RR_EN
    // ptr: 0 = ic, 1 = ld, 2 = st; search starts at ptr and wraps
    logic [1:0] ptr;

    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd1: begin
                if (elig[1])      grant = 3'b010;
                else if (elig[2]) grant = 3'b100;
                else if (elig[0]) grant = 3'b001;
            end
            2'd2: begin
                if (elig[2])      grant = 3'b100;
                else if (elig[0]) grant = 3'b001;
                else if (elig[1]) grant = 3'b010;
            end
            default: begin
                if (elig[0])      grant = 3'b001;
                else if (elig[1]) grant = 3'b010;
                else if (elig[2]) grant = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        grant = 3'b000;
        if (elig[2])      grant = 3'b100;
        else if (elig[1]) grant = 3'b010;
        else if (elig[0]) grant = 3'b001;
    end
`endif

    assign accept = rst_n && (state == IDLE) && (grant != 3'b000);
    assign rdy    = accept ? grant : 3'b000;

    assign ic_req_rdy = rdy[0];
    assign ld_req_rdy = rdy[1];
    assign st_req_rdy = rdy[2];

    assign l15_val = (state == ISSUE);

    // A done for a class that is not in flight is a no-op under the mask
    always_comb begin
        out_nxt = outstanding & ~{st_done, ld_done, ic_done};
        if (state == ISSUE && l15_header_ack) begin
            out_nxt = out_nxt | win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            win         <= 3'b000;
            outstanding <= 3'b000;
            l15_rqtype  <= 5'b00000;
            l15_address <= '0;
            l15_size    <= 3'b000;
            l15_data    <= '0;
        end else begin
            outstanding <= out_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        win   <= grant;
                        if (grant[2]) begin
                            l15_rqtype  <= STORE_RQ;
                            l15_address <= st_req_addr;
                            l15_size    <= st_req_size;
                            l15_data    <= st_req_data;
                        end else if (grant[1]) begin
                            l15_rqtype  <= LOAD_RQ;
                            l15_address <= ld_req_addr;
                            l15_size    <= ld_req_size;
                            l15_data    <= '0;
                        end else begin
                            l15_rqtype  <= IMISS_RQ;
                            l15_address <= ic_req_addr;
                            l15_size    <= 3'b111;
                            l15_data    <= '0;
                        end
                    end
                end
                default: begin
                    if (l15_header_ack) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ANYCORE_REQ_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (accept) begin
            if (grant[0])      ptr <= 2'd1;
            else if (grant[1]) ptr <= 2'd2;
            else               ptr <= 2'd0;
        end
    end
`endif

endmodule

// File: tb/tb_l15_anycore_req_arbiter.sv
// Scoreboard bench for l15_anycore_req_arbiter: queue-level reference model
// predicts grants and L1.5 requests; a monitor checks each issued request.
module tb_l15_anycore_req_arbiter;

    localparam int AW = 40;
    localparam int DW = 64;

    localparam int DIR  = 0;
    localparam int RAND = 1;
    localparam int CONT = 2;

    typedef struct {
        logic [4:0]    t;
        logic [AW-1:0] a;
        logic [2:0]    s;
        logic [DW-1:0] d;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    req_v = 3'b000;
    logic [AW-1:0] req_a [3];
    logic [2:0]    req_s [3];
    logic [DW-1:0] req_d [3];
    logic          ack = 1'b0;
    logic [2:0]    dn = 3'b000;

    logic          ic_req_rdy, ld_req_rdy, st_req_rdy;
    logic          l15_val;
    logic [4:0]    l15_rqtype;
    logic [AW-1:0] l15_address;
    logic [2:0]    l15_size;
    logic [DW-1:0] l15_data;
    logic [2:0]    outstanding;

    l15_anycore_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ic_req_val(req_v[0]),
        .ic_req_addr(req_a[0]),
        .ic_req_rdy(ic_req_rdy),
        .ld_req_val(req_v[1]),
        .ld_req_addr(req_a[1]),
        .ld_req_size(req_s[1]),
        .ld_req_rdy(ld_req_rdy),
        .st_req_val(req_v[2]),
        .st_req_addr(req_a[2]),
        .st_req_size(req_s[2]),
        .st_req_data(req_d[2]),
        .st_req_rdy(st_req_rdy),
        .l15_val(l15_val),
        .l15_rqtype(l15_rqtype),
        .l15_address(l15_address),
        .l15_size(l15_size),
        .l15_data(l15_data),
        .l15_header_ack(ack),
        .ic_done(dn[0]),
        .ld_done(dn[1]),
        .st_done(dn[2]),
        .outstanding(outstanding)
    );

    int n_cmp = 0;
    int n_bad = 0;

    txn_t expq[$];
    int   act_log[$];

    // Reference model state
    bit       m_busy = 0;
    bit [2:0] m_out = 3'b000;
    int       m_ptr = 0;
    int       m_win = 0;
    bit [2:0] granted = 3'b000;

    int mode = DIR;
    bit cont_done = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int pick();
`ifdef ANYCORE_REQ_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (req_v[c] && !m_out[c]) return c;
        end
`else
        for (int c = 2; c >= 0; c--) begin
            if (req_v[c] && !m_out[c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic txn_t mk_txn(input int c);
        txn_t x;
        x.t = (c == 0) ? 5'b10000 : (c == 1) ? 5'b00000 : 5'b00001;
        x.a = req_a[c];
        x.s = (c == 0) ? 3'b111 : req_s[c];
        x.d = (c == 2) ? req_d[2] : '0;
        return x;
    endfunction

    task automatic new_fields(input int c);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        req_a[c] = r[AW-1:0];
        req_s[c] = 3'($urandom_range(0, 7));
        req_d[c] = {$urandom(), $urandom()};
    endtask

    // Model + handshake checker
    always @(negedge clk) begin : model
        int       g;
        logic [2:0] exp_rdy;
        bit [2:0] nxt;
        g = -1;
        if (rst_n && !m_busy) g = pick();
        exp_rdy = 3'b000;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("rdy", {61'd0, st_req_rdy, ld_req_rdy, ic_req_rdy},
              {61'd0, exp_rdy});
        check("l15_val", {63'd0, l15_val}, {63'd0, m_busy});
        check("outstanding", {61'd0, outstanding}, {61'd0, m_out});
        if (st_req_rdy) act_log.push_back(2);
        else if (ld_req_rdy) act_log.push_back(1);
        else if (ic_req_rdy) act_log.push_back(0);
        if (!rst_n) begin
            m_busy = 0;
            m_out = 3'b000;
            m_ptr = 0;
        end else begin
            nxt = m_out & ~dn;
            if (m_busy && ack) begin
                nxt[m_win] = 1'b1;
                m_busy = 0;
            end
            m_out = nxt;
            if (g >= 0) begin
                expq.push_back(mk_txn(g));
                m_busy = 1;
                m_win = g;
                m_ptr = (g + 1) % 3;
                granted[g] = 1'b1;
            end
        end
    end

    // Monitor: pop on each new L1.5 request, then require stable fields
    txn_t cur;
    bit   seen = 0;
    always @(negedge clk) begin
        if (l15_val) begin
            if (!seen) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL issue: got unexpected request, expected none");
                end else begin
                    cur = expq.pop_front();
                end
                seen = 1;
            end
            check("l15_rqtype", {59'd0, l15_rqtype}, {59'd0, cur.t});
            check("l15_address", {24'd0, l15_address}, {24'd0, cur.a});
            check("l15_size", {61'd0, l15_size}, {61'd0, cur.s});
            check("l15_data", l15_data, cur.d);
        end else begin
            seen = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ack = 1'b0;
        dn = 3'b000;
        for (int c = 0; c < 3; c++) begin
            if (granted[c]) begin
                granted[c] = 1'b0;
                if (mode == CONT) begin
                    new_fields(c);
                end else begin
                    req_v[c] = 1'b0;
                    if (c == 2) req_d[2] = {$urandom(), $urandom()};
                end
            end
        end
        if (mode == RAND) begin
            for (int c = 0; c < 3; c++) begin
                if (!req_v[c] && $urandom_range(0, 3) == 0) begin
                    new_fields(c);
                    req_v[c] = 1'b1;
                end
                if (m_out[c] && $urandom_range(0, 4) == 0) dn[c] = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) dn[$urandom_range(0, 2)] = 1'b1;
            ack = ($urandom_range(0, 2) == 0);
        end else if (mode == CONT) begin
            req_v = 3'b111;
            ack = 1'b1;
            if (cont_done) dn = m_out;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            step();
            ack = 1'b1;
            dn = m_out;
        end
        step();
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            req_a[c] = '0;
            req_s[c] = '0;
            req_d[c] = '0;
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_val", {63'd0, l15_val}, 64'd0);
        check("reset_rqtype", {59'd0, l15_rqtype}, 64'd0);
        check("reset_address", {24'd0, l15_address}, 64'd0);
        check("reset_size", {61'd0, l15_size}, 64'd0);
        check("reset_data", l15_data, 64'd0);
        check("reset_outstanding", {61'd0, outstanding}, 64'd0);

        // Single load
        req_a[1] = 40'h80_0000_1000;
        req_s[1] = 3'd3;
        req_v[1] = 1'b1;
        step();
        step();
        ack = 1'b1;
        step();
        step();
        dn[1] = 1'b1;
        step();
        step();

        // Store held for 5 cycles before ack; data changes after accept
        req_a[2] = 40'h80_0000_2008;
        req_s[2] = 3'd3;
        req_d[2] = 64'hDEADBEEF_CAFEF00D;
        req_v[2] = 1'b1;
        step();
        repeat (5) step();
        ack = 1'b1;
        step();
        dn[2] = 1'b1;
        step();
        step();

        // Per-class blocking: second load waits, icache goes through
        req_a[1] = 40'h00_1234_5670;
        req_v[1] = 1'b1;
        step();
        ack = 1'b1;
        step();
        new_fields(1);
        req_v[1] = 1'b1;
        req_a[0] = 40'h00_0000_0040;
        req_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            ack = 1'b1;
        end
        dn[1] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            ack = 1'b1;
        end
        drain();

        // Spurious done
        dn[2] = 1'b1;
        step();
        step();

        // Reset mid-ISSUE with ic outstanding
        new_fields(0);
        req_v[0] = 1'b1;
        step();
        ack = 1'b1;
        step();
        new_fields(1);
        req_v[1] = 1'b1;
        step();
        rst_n = 1'b0;
        req_v = 3'b000;
        step();
        rst_n = 1'b1;
        check("rst_mid_val", {63'd0, l15_val}, 64'd0);
        check("rst_mid_outstanding", {61'd0, outstanding}, 64'd0);

        // Contention
        act_log.delete();
        mode = CONT;
`ifdef ANYCORE_REQ_ARB_RR_EN
        cont_done = 1;
`else
        cont_done = 0;
`endif
        repeat (12) step();
        begin
            int exp_ord[4];
`ifdef ANYCORE_REQ_ARB_RR_EN
            exp_ord = '{0, 1, 2, 0};
`else
            exp_ord = '{2, 1, 0, 0};
`endif
            for (int i = 0; i < 3; i++) begin
                if (act_log.size() > i)
                    check("grant_order", 64'(act_log[i]), 64'(exp_ord[i]));
                else
                    check("grant_order", 64'hFFFF, 64'(exp_ord[i]));
            end
`ifdef ANYCORE_REQ_ARB_RR_EN
            if (act_log.size() > 3)
                check("grant_order", 64'(act_log[3]), 64'(exp_ord[3]));
            else
                check("grant_order", 64'hFFFF, 64'(exp_ord[3]));
`endif
        end
        cont_done = 1;
        repeat (10) step();

        // Randomized traffic
        mode = RAND;
        repeat (3000) step();

        mode = DIR;
        req_v = 3'b000;
        drain();
        check("queue_empty", 64'(expq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
